// File: rtl/uart_command_emitter.sv
// Streams a latched command buffer to a UART TX byte interface, followed by the framing terminator.
// Latency: start sampled at edge N presents the first byte (tx_valid=1) right after edge N; 1 byte/cycle when tx_ready=1.
// Backpressure: tx_data/tx_valid hold while tx_ready=0; TIMEOUT consecutive stalled cycles abort the frame with error.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   start                 - one-cycle send request, sampled only in IDLE
//   input_data            - packed payload, byte i in [8i+7:8i]
//   input_data_size       - payload byte count (0..MAX_BYTES; larger sizes abort with error)
//   ble_side              - 1: terminator 0x0D, 0: terminator 0xBE,0xEF
//   tx_ready/tx_valid/tx_data - valid/ready byte stream to the UART TX
//   busy, done, error     - transfer in progress, end-of-transfer pulse, sticky error
//
// Optional build macro: UART_CMD_EMITTER_CHECKSUM_EN inserts an XOR checksum byte
// between the payload and the terminator.

module uart_command_emitter #(
  parameter int TIMEOUT   = 2000,
  parameter int MAX_BYTES = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1023:0] input_data,
  input  logic [7:0]    input_data_size,
  input  logic          ble_side,
  input  logic          tx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int CW = $clog2(TIMEOUT + 1);

`ifdef UART_CMD_EMITTER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, SEND, CHECK, TERM1, TERM2, FINISH} state_t;
`else
  typedef enum logic [2:0] {IDLE, SEND, TERM1, TERM2, FINISH} state_t;
`endif

  state_t          state_q, state_d;
  logic [1023:0]   data_q, data_d;
  logic [7:0]      size_q, size_d;
  logic            ble_q, ble_d;
  logic [6:0]      idx_q, idx_d;
  logic [CW-1:0]   stall_q, stall_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
`ifdef UART_CMD_EMITTER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic       accept;
  logic       last_byte;
  logic [6:0] idx_nxt;

  assign accept    = tx_valid_q && tx_ready;
  assign idx_nxt   = idx_q + 7'd1;
  // Index is 7 bits; size 1..MAX_BYTES so size-1 always fits.
  assign last_byte = ({1'b0, idx_q} == (size_q - 8'd1));

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    size_d     = size_q;
    ble_d      = ble_q;
    idx_d      = idx_q;
    stall_d    = stall_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
`ifdef UART_CMD_EMITTER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    // Stall watchdog: any presented byte that is not taken counts toward the abort.
    if (tx_valid_q) begin
      if (tx_ready) begin
        stall_d = '0;
      end else if (stall_q == CW'(TIMEOUT - 1)) begin
        stall_d    = '0;
        tx_valid_d = 1'b0;
        error_d    = 1'b1;
        done_d     = 1'b1;
        state_d    = FINISH;
      end else begin
        stall_d = stall_q + CW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        stall_d = '0;
        if (start) begin
          data_d  = input_data;
          size_d  = input_data_size;
          ble_d   = ble_side;
          idx_d   = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_CMD_EMITTER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
          if (int'(input_data_size) > MAX_BYTES) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = FINISH;
          end else if (input_data_size == 8'd0) begin
            tx_valid_d = 1'b1;
`ifdef UART_CMD_EMITTER_CHECKSUM_EN
            tx_data_d  = 8'h00;
            state_d    = CHECK;
`else
            tx_data_d  = ble_side ? 8'h0D : 8'hBE;
            state_d    = TERM1;
`endif
          end else begin
            // Bytes come straight from the inputs this edge; the latch is valid from the next.
            tx_valid_d = 1'b1;
            tx_data_d  = input_data[7:0];
            state_d    = SEND;
          end
        end
      end

      SEND: begin
        if (accept) begin
`ifdef UART_CMD_EMITTER_CHECKSUM_EN
          csum_d = csum_q ^ tx_data_q;
`endif
          if (last_byte) begin
`ifdef UART_CMD_EMITTER_CHECKSUM_EN
            tx_data_d = csum_q ^ tx_data_q;
            state_d   = CHECK;
`else
            tx_data_d = ble_q ? 8'h0D : 8'hBE;
            state_d   = TERM1;
`endif
          end else begin
            idx_d     = idx_nxt;
            tx_data_d = data_q[{idx_nxt, 3'b000} +: 8];
          end
        end
      end

`ifdef UART_CMD_EMITTER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          tx_data_d = ble_q ? 8'h0D : 8'hBE;
          state_d   = TERM1;
        end
      end
`endif

      TERM1: begin
        if (accept) begin
          if (ble_q) begin
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
            state_d    = FINISH;
          end else begin
            tx_data_d = 8'hEF;
            state_d   = TERM2;
          end
        end
      end

      TERM2: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = FINISH;
        end
      end

      FINISH: begin
        // done is high during this cycle; busy drops from the next one.
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      size_q     <= '0;
      ble_q      <= 1'b0;
      idx_q      <= '0;
      stall_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef UART_CMD_EMITTER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      size_q     <= size_d;
      ble_q      <= ble_d;
      idx_q      <= idx_d;
      stall_q    <= stall_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef UART_CMD_EMITTER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: doc/uart_command_emitter.md
Name: uart_command_emitter

Overview:
Transmit-side counterpart of the UART command accumulator. Takes a packed command buffer (byte 0 in bits [7:0], byte i in bits [8i+7:8i]) plus a byte count, and streams the bytes to a UART transmitter over a valid/ready byte interface. Appends the framing terminator: 0x0D on the BLE side, 0xBE 0xEF on the other side. Sits between the command/response logic and the UART TX.

Parameters:
TIMEOUT, 2000, maximum consecutive stalled cycles (tx_valid=1, tx_ready=0) before the transfer is aborted.
MAX_BYTES, 128, largest legal payload size (1024/8).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to send; sampled only in IDLE.
input_data  input  1024  packed payload; byte i is [8i+7:8i].
input_data_size  input  8  payload byte count, 0..MAX_BYTES.
ble_side  input  1  1: terminator is 0x0D; 0: terminator is 0xBE,0xEF.
tx_ready  input  1  UART TX can accept tx_data this cycle.
tx_data  output  8  byte presented to the UART TX.
tx_valid  output  1  tx_data is valid; a byte transfers on an edge where tx_valid=1 and tx_ready=1.
busy  output  1  transfer in progress.
done  output  1  one-cycle pulse when a transfer ends, whether success or abort.
error  output  1  sticky error flag; cleared on the next accepted start.

Behaviour:
- Reset (asynchronous, any state): tx_data=0, tx_valid=0, busy=0, done=0, error=0, byte index=0, stall counter=0, state=IDLE.
- States: IDLE, SEND, TERM1, TERM2, FINISH.
- IDLE:
  - On start=1: latch input_data, input_data_size and ble_side into internal registers; clear error; set busy=1.
  - If size>MAX_BYTES: set error=1, go to FINISH, send nothing.
  - Else if size=0: go to TERM1.
  - Else: go to SEND with index=0.
- Latency: start sampled at edge N gives tx_valid=1 with the first byte after edge N.
- Later changes on inputs do not affect a transfer once its start has been accepted.
- SEND:
  - tx_valid=1, tx_data=latched byte[index].
  - On accept: index+1. If the accepted byte was index=size-1, go to TERM1.
  - tx_valid stays high through byte boundaries, so back-to-back throughput is 1 byte/cycle.
  - tx_data and tx_valid hold stable while tx_ready=0.
- Payload bytes equal to 0x0D, 0xBE or 0xEF are sent raw. There is no escaping.
- TERM1: tx_data=0x0D if latched ble_side, else 0xBE. On accept: go to FINISH if ble_side, else go to TERM2.
- TERM2: tx_data=0xEF. On accept: go to FINISH.
- FINISH: tx_valid=0, done=1 for exactly one cycle, busy=0 from the following cycle, return to IDLE.
- Stall timeout:
  - The counter increments each cycle tx_valid=1 and tx_ready=0.
  - It clears on every accepted byte and in IDLE.
  - When the counter reaches TIMEOUT: deassert tx_valid the next cycle, set error=1, go to FINISH. The partial frame is not completed.
- start while busy=1 is ignored, with no queuing.
- Reset mid-transfer aborts immediately; tx_valid drops asynchronously and no done pulse occurs.
- Total accepted bytes per frame: size+1 if ble_side, size+2 otherwise (one more with the optional feature).

Optional Feature:
Macro UART_CMD_EMITTER_CHECKSUM_EN.
- Defined: an XOR-of-all-payload-bytes checksum byte is sent between the last payload byte and the terminator, through a CHECK state entered from SEND (or from IDLE when size=0, where checksum=0x00). The running XOR is cleared on start.
- Undefined: no CHECK state and no checksum logic; the frame is payload followed by the terminator.

Test Plan:
1. ble_side=1, size=3, data bytes 0x41,0x42,0x43, tx_ready=1 -> tx_data 0x41,0x42,0x43,0x0D on 4 consecutive cycles, then done=1 for one cycle, error=0.
2. ble_side=0, size=2, bytes 0x10,0x20, tx_ready toggling 1,0,1,0 -> accepted sequence 0x10,0x20,0xBE,0xEF; tx_data stable during every tx_ready=0 cycle.
3. size=0, ble_side=0 -> exactly 0xBE,0xEF sent, then done.
4. size=200 -> no tx_valid, error=1, done pulse, busy=0; a following valid start clears error.
5. TIMEOUT=10, tx_ready held 0 after the first byte -> tx_valid drops after 10 stalled cycles, error=1, done=1; start asserted while busy during the stall is ignored.
6. reset asserted mid-SEND -> all outputs 0 immediately; a next start sends a full, correct frame.
